// File: rtl/i2s_tx_master.sv
// ---------------------------------------------------------------------------
// i2s_tx_master
//
// I2S master transmitter. It derives the bit clock (sclk_o) and word select
// (ws_o) from clk_i and shifts stereo PCM samples out MSB-first on sdata_o.
// Data follows each ws transition by one sclk period, as I2S requires.
// A one-entry holding register with a valid/ready handshake decouples the
// sample producer from frame timing.
//
// Parameters:
//   WIDTH      sample width per channel in bits
//   SLOT_BITS  sclk periods per channel slot (>= WIDTH); unused bits are 0
//   SCLK_HALF  clk_i cycles per sclk_o half-period (>= 1)
//
// Ports:
//   clk_i        system clock, all logic on the rising edge
//   rst_i        asynchronous active-low reset
//   leftChan_i   left sample, two's complement
//   rightChan_i  right sample
//   pktValid_i   producer offers a sample pair
//   pktReady_o   holding register empty; the pair is taken on valid && ready
//   sclk_o       bit clock
//   ws_o         word select, 0 = left slot, 1 = right slot
//   sdata_o      serial data
//   underrun_o   one-cycle pulse when a frame starts with no pair available
// ---------------------------------------------------------------------------
module i2s_tx_master #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 16,
  parameter int SCLK_HALF = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] leftChan_i,
  input  logic [WIDTH-1:0] rightChan_i,
  input  logic             pktValid_i,
  output logic             pktReady_o,
  output logic             sclk_o,
  output logic             ws_o,
  output logic             sdata_o,
  output logic             underrun_o
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int POS_W = $clog2(FRAME);
  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME - 1);
  localparam logic [POS_W-1:0] SLOT_POS = POS_W'(SLOT_BITS);
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(SCLK_HALF - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             ws_q, ws_d;
  logic             sdata_q, sdata_d;
  logic             underrun_q, underrun_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] hold_r_q, hold_r_d;
  logic             full_q, full_d;

  logic             div_tc;
  logic             fall_evt;
  logic             frame_start;
  logic [POS_W-1:0] pos_next;
  logic [FRAME-1:0] load_word;

  // Frame image: left sample at the top of the first slot, right sample at
  // the top of the second slot, zero padding below each. Built with shifts
  // so that SLOT_BITS == WIDTH (no padding) needs no special case.
  assign load_word = (FRAME'(hold_l_q) << (FRAME - WIDTH)) |
                     (FRAME'(hold_r_q) << (SLOT_BITS - WIDTH));

  always_comb begin
    div_tc      = (div_q == DIV_TC);
    fall_evt    = div_tc && sclk_q;
    pos_next    = (pos_q == LAST_POS) ? '0 : pos_q + POS_W'(1);
    frame_start = fall_evt && (pos_q == LAST_POS);

    div_d      = div_tc ? '0 : div_q + DIV_W'(1);
    sclk_d     = div_tc ? ~sclk_q : sclk_q;
    ws_d       = ws_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    pos_d      = pos_q;
    shift_d    = shift_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    full_d     = full_q;

    // Everything on the serial side moves on the sclk falling edge so the
    // data is settled by the time the receiver samples on the rising edge.
    if (fall_evt) begin
      pos_d   = pos_next;
      ws_d    = (pos_next >= SLOT_POS);
      // The outgoing bit is the old MSB even at frame start; this is what
      // delays the data one bit behind ws.
      sdata_d = shift_q[FRAME-1];
      if (frame_start) begin
        shift_d    = full_q ? load_word : '0;
        underrun_d = ~full_q;
      end else begin
        shift_d = shift_q << 1;
      end
    end

    // ready is the registered empty flag, so a pair offered in the very
    // cycle an empty register is sampled for a frame start is taken for the
    // following frame, and that frame underruns.
    if (pktValid_i && !full_q) begin
      hold_l_d = leftChan_i;
      hold_r_d = rightChan_i;
      full_d   = 1'b1;
    end else if (frame_start && full_q) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_q      <= '0;
      sclk_q     <= 1'b0;
      ws_q       <= 1'b1;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      pos_q      <= LAST_POS;
      shift_q    <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      full_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      ws_q       <= ws_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      pos_q      <= pos_d;
      shift_q    <= shift_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      full_q     <= full_d;
    end
  end

  assign pktReady_o = ~full_q;
  assign sclk_o     = sclk_q;
  assign ws_o       = ws_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;

endmodule

// File: doc/i2s_tx_master.md
Name: i2s_tx_master

Overview:
- I2S master transmitter. Runs on one system clock and generates sclk_o and ws_o from it.
- Serialises stereo PCM samples MSB-first onto sdata_o, using the standard I2S one-bit delay after each ws transition.
- A one-entry holding register, with a valid/ready handshake, decouples the sample producer (audio pipeline / async FIFO read side) from frame timing.
- Sits at the DAC/codec output end of the audio path, opposite the I2S receiver.

Parameters:
- WIDTH, 16, sample width per channel in bits.
- SLOT_BITS, 16, sclk periods per channel slot; must be >= WIDTH. Bits after the sample LSB are driven 0.
- SCLK_HALF, 2, clk_i cycles per sclk_o half-period; must be >= 1.

Ports:
- clk_i  in  1  system clock; all logic on posedge.
- rst_i  in  1  asynchronous, active-low reset.
- leftChan_i  in  WIDTH  left sample, two's complement.
- rightChan_i  in  WIDTH  right sample.
- pktValid_i  in  1  producer has a sample pair on leftChan_i/rightChan_i.
- pktReady_o  out  1  holding register empty; a pair is accepted on a cycle where pktValid_i && pktReady_o.
- sclk_o  out  1  bit clock.
- ws_o  out  1  word select; 0 = left slot, 1 = right slot.
- sdata_o  out  1  serial data.
- underrun_o  out  1  one-cycle pulse: frame started with no sample pair available.

Behaviour:
- Reset (rst_i low, async): sclk_o=0, ws_o=1, sdata_o=0, underrun_o=0, pktReady_o=1.
  - Holding register empty and zeroed; 2*SLOT_BITS shift register zeroed.
  - divCnt=0; bitPos=2*SLOT_BITS-1.
  - Release mid-frame: the stream restarts cleanly from this state; no partial sample is emitted.
- Divider:
  - divCnt counts 0..SCLK_HALF-1. At terminal count it wraps to 0 and sclk_o toggles.
  - A "fall event" is the cycle in which sclk_o toggles 1->0.
  - sclk period = 2*SCLK_HALF clk cycles; 50% duty cycle.
- All of ws_o, sdata_o, bitPos, shift register and underrun_o update only on fall events, in the same clk cycle sclk_o goes low. Data is therefore stable across the sclk rising edge.
- bitPos on each fall event: bitPos <= (bitPos==2*SLOT_BITS-1) ? 0 : bitPos+1.
  - ws_o <= 0 when the new bitPos < SLOT_BITS, else 1.
- Shift register layout, loaded as: {left sample, (SLOT_BITS-WIDTH) zeros, right sample, (SLOT_BITS-WIDTH) zeros}.
- Every fall event: sdata_o <= shift MSB, then shift left by 1, filling with 0.
- Frame start (fall event where new bitPos=0):
  - sdata_o takes the old shift MSB (last right-slot bit, giving the one-bit I2S delay).
  - The shift register is then loaded from the holding register and the holding register is marked empty.
  - Resulting stream: left MSB appears at bitPos 1; right MSB at bitPos SLOT_BITS+1.
- Underrun: at frame start with the holding register empty:
  - Load all zeros.
  - underrun_o=1 for exactly that clk cycle.
  - Stream timing unaffected.
- Handshake:
  - pktReady_o = holding register empty (registered state; no combinational path from pktValid_i).
  - On accept, the holding register captures both inputs and pktReady_o deasserts next cycle.
  - A pair offered in the same cycle as a frame-start load with an empty holding register: that frame underruns (zeros), and the pair is captured for the next frame.
  - With a full holding register, pktValid_i is ignored; the producer must hold its data.
- First frame after reset: ws_o transitions 1->0 at the first fall event, which is a frame start. Reset-to-first-fall = 2*SCLK_HALF clk cycles (sclk_o rises after SCLK_HALF, falls after 2*SCLK_HALF).
- Throughput: one sample pair per 2*SLOT_BITS*2*SCLK_HALF clk cycles.

Test Plan:
- Reset values: hold rst_i low 5 cycles, release.
  - During reset: sclk_o=0, ws_o=1, sdata_o=0, pktReady_o=1, underrun_o=0.
  - sclk_o rises at cycle 2 and falls at cycle 4 after release; ws_o goes 0 on that fall.
- Single frame, defaults: offer L=16'hA5C3, R=16'h0F0F before the first frame start.
  - Sampled on sclk rising edges: bitPos0 = 0 (prior pad).
  - bitPos1..16 = 1010_0101_1100_0011.
  - bitPos17 = 0, ws_o=1 from bitPos16.
  - bitPos17.. = 0000_1111_0000_1111 (right MSB-first; its LSB lands at next frame's bitPos0).
- Underrun: no valid offered.
  - underrun_o pulses once per frame start; sdata_o stays 0; sclk/ws timing unchanged.
- Backpressure: hold pktValid_i=1 with incrementing pairs.
  - Exactly one accept per frame; pktReady_o low from accept until the next frame-start load.
  - No pair dropped or duplicated over 8 frames.
- Padding: SLOT_BITS=32, WIDTH=16, L=16'hFFFF, R=16'h8001.
  - Left slot: 16 ones then 16 zeros.
  - Right slot: 1, 14 zeros, 1, then 16 zeros.
  - ws period = 64 sclk.
- Reset mid-frame: assert rst_i at bitPos 9 of the left slot.
  - Outputs go to reset values immediately, asynchronously.
  - After release, the stream restarts at frame start with fresh holding-register contents.
